pipeline_hazard_controller: RTL and testbench
=============================================

# pipeline_hazard_controller

Central stall/flush sequencer for the RV32IM 5-stage pipeline. Each cycle it decides, for every pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB), whether the register holds its value (stall), loads a bubble (flush) or advances. It resolves data-memory and instruction-memory wait states, load-use hazards, taken-branch redirects and multi-cycle M-extension divide occupancy of EX. A small FSM with a cycle counter tracks divide occupancy.

## Interface
- DIV_CYCLES, default 32: total cycles a divide/remainder op occupies EX; legal range 2..63.
- CLK  in  1  pipeline clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- IMEM_BUSYWAIT  in  1  instruction memory has not returned the fetch.
- DMEM_BUSYWAIT  in  1  data memory access in MEM is not complete.
- ID_RS1, ID_RS2  in  5 each  source register numbers of the instruction in ID.
- ID_USES_RS1, ID_USES_RS2  in  1 each  ID instruction actually reads that source.
- EX_RD  in  5  destination register of the instruction in EX.
- EX_MEM_READ  in  1  instruction in EX is a load.
- EX_DIV_START  in  1  instruction in EX is DIV/DIVU/REM/REMU.
- EX_BRANCH_TAKEN  in  1  EX resolved a taken branch or jump.
- PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL, MEM_WB_STALL  out  1 each  hold register (drives that register's BUSYWAIT).
- IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MEM_WB_FLUSH  out  1 each  load bubble (RESET input of that register).
- DIV_EN  out  1  divider advances one step this cycle.
- DIV_DONE  out  1  final divide cycle; EX/MEM captures the result.
- DIV_BUSY  out  1  FSM is in DIV_WAIT.

## Operation
- FSM states: RUN, DIV_WAIT. Register div_cnt is 6 bits.
- Outputs are combinational from state, div_cnt and inputs. A STALL and a FLUSH are never both high for the same register.
- Rules are evaluated in the priority order below. The first matching rule sets the outputs. Every output a rule does not name is 0.
  1. RESET: all FLUSH = 1. Next state is RUN and div_cnt = 0.
  2. DMEM_BUSYWAIT: all five STALL = 1 and DIV_EN = 0. State and div_cnt are frozen.
  3. DIV_WAIT with div_cnt > 1: PC, IF/ID and ID/EX stall; EX_MEM_FLUSH = 1; DIV_EN = 1; div_cnt decrements.
  4. DIV_WAIT with div_cnt == 1: DIV_DONE = 1 and DIV_EN = 1. Pipeline advances. Next state is RUN and div_cnt = 0. Branch and load-use are not checked this cycle, because EX holds the divide.
  5. RUN with EX_DIV_START: PC, IF/ID and ID/EX stall; EX_MEM_FLUSH = 1; DIV_EN = 1. Next state is DIV_WAIT with div_cnt = DIV_CYCLES-1. If EX_BRANCH_TAKEN is also high, divide wins and the branch is ignored.
  6. EX_BRANCH_TAKEN: IF_ID_FLUSH = 1 and ID_EX_FLUSH = 1. PC_STALL = 0 even if IMEM_BUSYWAIT is high, so the PC loads the target.
  7. Load-use: this rule fires when EX_MEM_READ is high, EX_RD != 0, and either (ID_USES_RS1 and ID_RS1 == EX_RD) or (ID_USES_RS2 and ID_RS2 == EX_RD). Outputs: PC_STALL = 1, IF_ID_STALL = 1, ID_EX_FLUSH = 1. This takes precedence over IMEM_BUSYWAIT.
  8. IMEM_BUSYWAIT: PC_STALL = 1 and IF_ID_FLUSH = 1.
  9. Otherwise all outputs are 0 and every register advances.
- Register x0 never creates a load-use hazard.

## Timing
- Reset values: during the RESET cycle all FLUSH outputs are 1 and every other output is 0. State is RUN and div_cnt = 0 from the first edge with RESET high.
- RESET mid-divide: on the next edge, the FSM returns to RUN, div_cnt = 0 and DIV_BUSY = 0. No DIV_DONE is produced.
- Load-use costs exactly 1 bubble. On the next cycle the load is in MEM and the rule no longer matches.
- Divide timing when EX_DIV_START rises in cycle t:
  - Stalls are asserted in cycles t .. t+DIV_CYCLES-2.
  - DIV_DONE is high in cycle t+DIV_CYCLES-1.
  - EX occupancy is DIV_CYCLES cycles total.
  - DIV_BUSY is high in cycles t+1 .. t+DIV_CYCLES-1.
- Each DMEM_BUSYWAIT cycle during a divide lengthens the divide by 1 cycle, because div_cnt is frozen.
- Branch flush takes 1 cycle and leaves 2 bubbles: the IF/ID and ID/EX instructions are discarded.

## Test plan
- Reset: assert RESET for 2 cycles while in DIV_WAIT -> all FLUSH = 1, DIV_BUSY = 0 after the first edge, and no DIV_DONE afterwards.
- Load-use: EX_MEM_READ = 1, EX_RD = 5, ID_RS2 = 5, ID_USES_RS2 = 1 -> one cycle of PC_STALL = IF_ID_STALL = ID_EX_FLUSH = 1. Repeat with EX_RD = 0 -> no stall.
- Divide, DIV_CYCLES = 4, EX_DIV_START at cycle 10 -> stalls plus EX_MEM_FLUSH in cycles 10–12, DIV_DONE in cycle 13, DIV_BUSY in cycles 11–13.
- Divide with DMEM_BUSYWAIT held 2 cycles at cycle 11 -> all STALL = 1 and DIV_EN = 0 in cycles 11–12; DIV_DONE moves to cycle 15.
- EX_BRANCH_TAKEN together with IMEM_BUSYWAIT -> IF_ID_FLUSH = ID_EX_FLUSH = 1 and PC_STALL = 0. The next cycle with IMEM_BUSYWAIT alone -> PC_STALL = IF_ID_FLUSH = 1.
- Load-use hazard together with IMEM_BUSYWAIT -> IF_ID_STALL = 1, IF_ID_FLUSH = 0, PC_STALL = 1, ID_EX_FLUSH = 1.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
//
// Central stall/flush sequencer for the 5-stage RV32IM pipeline. Every cycle
// it decides, per pipeline register, whether to hold (STALL), load a bubble
// (FLUSH) or advance. Resolves data/instruction memory wait states, load-use
// hazards, taken-branch redirects and multi-cycle divide occupancy of EX.
//
// State table:
//   state    | meaning
//   RUN      | normal operation, no divide in flight
//   DIV_WAIT | divide occupying EX; div_cnt counts cycles left until DIV_DONE
//
// Ports:
//   CLK, RESET                 clock, synchronous active-high reset
//   IMEM_BUSYWAIT              fetch not yet returned
//   DMEM_BUSYWAIT              MEM-stage data access not complete
//   ID_RS1/ID_RS2, ID_USES_*   sources read by the instruction in ID
//   EX_RD, EX_MEM_READ         destination / load flag of the instruction in EX
//   EX_DIV_START               instruction in EX is a divide/remainder
//   EX_BRANCH_TAKEN            EX resolved a taken branch or jump
//   *_STALL                    hold the corresponding pipeline register
//   *_FLUSH                    load a bubble into the corresponding register
//   DIV_EN, DIV_DONE, DIV_BUSY divider step enable, final step, FSM busy

module pipeline_hazard_controller #(
  parameter int DIV_CYCLES = 32
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       IMEM_BUSYWAIT,
  input  logic       DMEM_BUSYWAIT,
  input  logic [4:0] ID_RS1,
  input  logic [4:0] ID_RS2,
  input  logic       ID_USES_RS1,
  input  logic       ID_USES_RS2,
  input  logic [4:0] EX_RD,
  input  logic       EX_MEM_READ,
  input  logic       EX_DIV_START,
  input  logic       EX_BRANCH_TAKEN,
  output logic       PC_STALL,
  output logic       IF_ID_STALL,
  output logic       ID_EX_STALL,
  output logic       EX_MEM_STALL,
  output logic       MEM_WB_STALL,
  output logic       IF_ID_FLUSH,
  output logic       ID_EX_FLUSH,
  output logic       EX_MEM_FLUSH,
  output logic       MEM_WB_FLUSH,
  output logic       DIV_EN,
  output logic       DIV_DONE,
  output logic       DIV_BUSY
);

  typedef enum logic {
    RUN      = 1'b0,
    DIV_WAIT = 1'b1
  } state_t;

  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  state_t     state, state_next;
  logic [5:0] div_cnt, div_cnt_next;
  logic       load_use;

  // x0 is hardwired to zero, so a load targeting it can never feed ID.
  assign load_use = EX_MEM_READ && (EX_RD != 5'd0) &&
                    ((ID_USES_RS1 && (ID_RS1 == EX_RD)) ||
                     (ID_USES_RS2 && (ID_RS2 == EX_RD)));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= RUN;
      div_cnt <= 6'd0;
    end else begin
      state   <= state_next;
      div_cnt <= div_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    div_cnt_next = div_cnt;
    PC_STALL     = 1'b0;
    IF_ID_STALL  = 1'b0;
    ID_EX_STALL  = 1'b0;
    EX_MEM_STALL = 1'b0;
    MEM_WB_STALL = 1'b0;
    IF_ID_FLUSH  = 1'b0;
    ID_EX_FLUSH  = 1'b0;
    EX_MEM_FLUSH = 1'b0;
    MEM_WB_FLUSH = 1'b0;
    DIV_EN       = 1'b0;
    DIV_DONE     = 1'b0;
    // Busy reflects the FSM state, but is masked while reset is applied so
    // that the reset cycle presents only the flushes.
    DIV_BUSY     = (state == DIV_WAIT) && !RESET;

    if (RESET) begin
      IF_ID_FLUSH  = 1'b1;
      ID_EX_FLUSH  = 1'b1;
      EX_MEM_FLUSH = 1'b1;
      MEM_WB_FLUSH = 1'b1;
      state_next   = RUN;
      div_cnt_next = 6'd0;
    end else if (DMEM_BUSYWAIT) begin
      // Whole pipe freezes, including the divider and its counter.
      PC_STALL     = 1'b1;
      IF_ID_STALL  = 1'b1;
      ID_EX_STALL  = 1'b1;
      EX_MEM_STALL = 1'b1;
      MEM_WB_STALL = 1'b1;
    end else if ((state == DIV_WAIT) && (div_cnt > 6'd1)) begin
      PC_STALL     = 1'b1;
      IF_ID_STALL  = 1'b1;
      ID_EX_STALL  = 1'b1;
      EX_MEM_FLUSH = 1'b1;
      DIV_EN       = 1'b1;
      div_cnt_next = div_cnt - 6'd1;
    end else if (state == DIV_WAIT) begin
      // Final divide step: EX holds the divide, so branch/load-use cannot apply.
      DIV_DONE     = 1'b1;
      DIV_EN       = 1'b1;
      state_next   = RUN;
      div_cnt_next = 6'd0;
    end else if (EX_DIV_START) begin
      PC_STALL     = 1'b1;
      IF_ID_STALL  = 1'b1;
      ID_EX_STALL  = 1'b1;
      EX_MEM_FLUSH = 1'b1;
      DIV_EN       = 1'b1;
      state_next   = DIV_WAIT;
      div_cnt_next = DIV_LOAD;
    end else if (EX_BRANCH_TAKEN) begin
      // PC must load the target even while the fetch is pending.
      IF_ID_FLUSH  = 1'b1;
      ID_EX_FLUSH  = 1'b1;
    end else if (load_use) begin
      PC_STALL     = 1'b1;
      IF_ID_STALL  = 1'b1;
      ID_EX_FLUSH  = 1'b1;
    end else if (IMEM_BUSYWAIT) begin
      PC_STALL     = 1'b1;
      IF_ID_FLUSH  = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

  localparam int DC = 4;

  logic       CLK = 1'b0;
  logic       RESET, IMEM_BUSYWAIT, DMEM_BUSYWAIT;
  logic [4:0] ID_RS1, ID_RS2, EX_RD;
  logic       ID_USES_RS1, ID_USES_RS2, EX_MEM_READ, EX_DIV_START, EX_BRANCH_TAKEN;
  logic       PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL, MEM_WB_STALL;
  logic       IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MEM_WB_FLUSH;
  logic       DIV_EN, DIV_DONE, DIV_BUSY;

  int passed = 0;
  int total  = 0;

  // Reference model: divide tracked as "busy" plus the number of unfrozen
  // stall cycles still owed before the completion cycle.
  bit m_busy = 0;
  int m_owed = 0;

  pipeline_hazard_controller #(.DIV_CYCLES(DC)) dut (
    .CLK(CLK), .RESET(RESET),
    .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .DMEM_BUSYWAIT(DMEM_BUSYWAIT),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
    .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
    .EX_RD(EX_RD), .EX_MEM_READ(EX_MEM_READ),
    .EX_DIV_START(EX_DIV_START), .EX_BRANCH_TAKEN(EX_BRANCH_TAKEN),
    .PC_STALL(PC_STALL), .IF_ID_STALL(IF_ID_STALL), .ID_EX_STALL(ID_EX_STALL),
    .EX_MEM_STALL(EX_MEM_STALL), .MEM_WB_STALL(MEM_WB_STALL),
    .IF_ID_FLUSH(IF_ID_FLUSH), .ID_EX_FLUSH(ID_EX_FLUSH),
    .EX_MEM_FLUSH(EX_MEM_FLUSH), .MEM_WB_FLUSH(MEM_WB_FLUSH),
    .DIV_EN(DIV_EN), .DIV_DONE(DIV_DONE), .DIV_BUSY(DIV_BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic logic [11:0] dut_vec();
    return {PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL, MEM_WB_STALL,
            IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MEM_WB_FLUSH,
            DIV_EN, DIV_DONE, DIV_BUSY};
  endfunction

  // Expected outputs straight from the priority rules.
  function automatic logic [11:0] model_vec();
    logic [4:0] stl, fl;
    logic en, dn, bz, hz;
    stl = '0; fl = '0; en = 0; dn = 0;
    bz  = m_busy && !RESET;
    hz  = EX_MEM_READ && EX_RD != 0 &&
          ((ID_USES_RS1 && ID_RS1 == EX_RD) || (ID_USES_RS2 && ID_RS2 == EX_RD));
    if (RESET)                           fl = 5'b01111;
    else if (DMEM_BUSYWAIT)              stl = 5'b11111;
    else if (m_busy && m_owed > 0)       begin stl = 5'b11100; fl = 5'b00010; en = 1; end
    else if (m_busy)                     begin dn = 1; en = 1; end
    else if (EX_DIV_START)               begin stl = 5'b11100; fl = 5'b00010; en = 1; end
    else if (EX_BRANCH_TAKEN)            fl = 5'b01100;
    else if (hz)                         begin stl = 5'b11000; fl = 5'b00100; end
    else if (IMEM_BUSYWAIT)              begin stl = 5'b10000; fl = 5'b01000; end
    // fl[4] keeps the vector aligned with stl; the PC has no flush, so it is dropped.
    return {stl, fl[3:0], en, dn, bz};
  endfunction

  task automatic model_edge();
    if (RESET) m_busy = 0;
    else if (DMEM_BUSYWAIT) ;
    else if (m_busy && m_owed > 0) m_owed--;
    else if (m_busy) m_busy = 0;
    else if (EX_DIV_START) begin m_busy = 1; m_owed = DC - 2; end
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    RESET = 0; IMEM_BUSYWAIT = 0; DMEM_BUSYWAIT = 0;
    ID_RS1 = 0; ID_RS2 = 0; ID_USES_RS1 = 0; ID_USES_RS2 = 0;
    EX_RD = 0; EX_MEM_READ = 0; EX_DIV_START = 0; EX_BRANCH_TAKEN = 0;
  endtask

  // Inputs are set just after negedge; sample here, before the rising edge.
  task automatic sample(input string tag);
    #1;
    chk(tag, dut_vec(), model_vec());
    chk({tag, "_excl"},
        12'({IF_ID_STALL & IF_ID_FLUSH, ID_EX_STALL & ID_EX_FLUSH,
             EX_MEM_STALL & EX_MEM_FLUSH, MEM_WB_STALL & MEM_WB_FLUSH}), 12'd0);
  endtask

  task automatic advance();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  initial begin
    idle_inputs();
    RESET = 1;
    @(negedge CLK);

    // Reset state
    sample("reset0");
    chk("reset_flush", 12'({IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MEM_WB_FLUSH}), 12'hF);
    advance();
    sample("reset1");
    advance();
    RESET = 0;

    // Load-use on rs2 then x0 destination
    EX_MEM_READ = 1; EX_RD = 5; ID_RS2 = 5; ID_USES_RS2 = 1;
    sample("lu");
    chk("lu_direct", 12'({PC_STALL, IF_ID_STALL, ID_EX_FLUSH, IF_ID_FLUSH}), 12'b1110);
    advance();
    EX_MEM_READ = 0;
    sample("lu_after");
    chk("lu_one_bubble", 12'({PC_STALL, IF_ID_STALL, ID_EX_FLUSH}), 12'd0);
    advance();
    EX_MEM_READ = 1; EX_RD = 0; ID_RS2 = 0;
    sample("lu_x0");
    chk("lu_x0_direct", 12'({PC_STALL, IF_ID_STALL, ID_EX_FLUSH}), 12'd0);
    advance();
    idle_inputs();

    // Divide, no interruption: start t, stalls t..t+2, done t+3
    for (int c = 0; c < DC + 1; c++) begin
      EX_DIV_START = (c < DC);
      EX_BRANCH_TAKEN = (c == 0);
      sample($sformatf("div_c%0d", c));
      chk($sformatf("div_done_c%0d", c), 12'(DIV_DONE), 12'(c == DC - 1));
      chk($sformatf("div_busy_c%0d", c), 12'(DIV_BUSY), 12'(c >= 1 && c <= DC - 1));
      chk($sformatf("div_stall_c%0d", c), 12'({PC_STALL, EX_MEM_FLUSH}),
          (c <= DC - 2) ? 12'b11 : 12'b00);
      advance();
    end
    idle_inputs();

    // Divide with DMEM wait at t+1, t+2: done moves to t+5
    for (int c = 0; c < DC + 3; c++) begin
      EX_DIV_START  = (c < DC + 2);
      DMEM_BUSYWAIT = (c == 1 || c == 2);
      sample($sformatf("divd_c%0d", c));
      chk($sformatf("divd_done_c%0d", c), 12'(DIV_DONE), 12'(c == DC + 1));
      if (c == 1 || c == 2)
        chk($sformatf("divd_freeze_c%0d", c),
            12'({PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL, MEM_WB_STALL, DIV_EN}),
            12'b111110);
      advance();
    end
    idle_inputs();

    // Branch with IMEM wait, then IMEM wait alone
    EX_BRANCH_TAKEN = 1; IMEM_BUSYWAIT = 1;
    sample("br_imem");
    chk("br_imem_direct", 12'({IF_ID_FLUSH, ID_EX_FLUSH, PC_STALL}), 12'b110);
    advance();
    EX_BRANCH_TAKEN = 0;
    sample("imem_only");
    chk("imem_direct", 12'({PC_STALL, IF_ID_FLUSH}), 12'b11);
    advance();

    // Load-use beats IMEM wait
    EX_MEM_READ = 1; EX_RD = 9; ID_RS1 = 9; ID_USES_RS1 = 1;
    sample("lu_imem");
    chk("lu_imem_direct", 12'({IF_ID_STALL, IF_ID_FLUSH, PC_STALL, ID_EX_FLUSH}), 12'b1011);
    advance();
    idle_inputs();

    // Reset for 2 cycles mid-divide; no DIV_DONE afterwards
    EX_DIV_START = 1;
    sample("rdiv_start");
    advance();
    sample("rdiv_busy");
    advance();
    RESET = 1;
    for (int c = 0; c < 2; c++) begin
      sample($sformatf("rdiv_rst%0d", c));
      advance();
    end
    idle_inputs();
    for (int c = 0; c < DC + 1; c++) begin
      sample($sformatf("rdiv_post%0d", c));
      chk($sformatf("rdiv_nodone%0d", c), 12'({DIV_DONE, DIV_BUSY}), 12'd0);
      advance();
    end

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      RESET           = ($urandom_range(0, 49) == 0);
      DMEM_BUSYWAIT   = ($urandom_range(0, 5) == 0);
      IMEM_BUSYWAIT   = ($urandom_range(0, 3) == 0);
      EX_DIV_START    = ($urandom_range(0, 7) == 0);
      EX_BRANCH_TAKEN = ($urandom_range(0, 4) == 0);
      EX_MEM_READ     = ($urandom_range(0, 2) == 0);
      EX_RD           = 5'($urandom_range(0, 3));
      ID_RS1          = 5'($urandom_range(0, 3));
      ID_RS2          = 5'($urandom_range(0, 3));
      ID_USES_RS1     = 1'($urandom_range(0, 1));
      ID_USES_RS2     = 1'($urandom_range(0, 1));
      sample($sformatf("rnd%0d", i));
      advance();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
